servant_wb_decoder: RTL

Parametrised Wishbone data-bus decoder, the successor to the fixed four-way servant data-bus mux. It routes the CPU dbus to NUM_SLAVES peripherals, selected by an address field, and waits for a per-slave ack with variable latency. A per-transaction timeout watchdog returns an error response if a slave never acks. It sits between the serv dbus and the RAM, GPIO, timer, flash and debug-module slaves.

---
 rtl/servant_wb_decoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/servant_wb_decoder.sv
// Wishbone data-bus decoder: routes the serv dbus to NUM_SLAVES peripherals by an
// address field, waits for a variable-latency ack and answers with an error on timeout.
module servant_wb_decoder #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_MSB    = 31,
    parameter int          SEL_WIDTH  = 2,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                       wb_clk,
    input  logic                       wb_rstn,
    input  logic [31:0]                i_wb_cpu_adr,
    input  logic [31:0]                i_wb_cpu_dat,
    input  logic [3:0]                 i_wb_cpu_sel,
    input  logic                       i_wb_cpu_we,
    input  logic                       i_wb_cpu_cyc,
    output logic [31:0]                o_wb_cpu_rdt,
    output logic                       o_wb_cpu_ack,
    output logic [31:0]                o_wb_s_adr,
    output logic [31:0]                o_wb_s_dat,
    output logic [3:0]                 o_wb_s_sel,
    output logic                       o_wb_s_we,
    output logic [NUM_SLAVES-1:0]      o_wb_s_cyc,
    input  logic [32*NUM_SLAVES-1:0]   i_wb_s_rdt,
    input  logic [NUM_SLAVES-1:0]      i_wb_s_ack,
    output logic                       o_err,
    output logic [31:0]                o_err_adr
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SEL_WIDTH-1:0] req_idx;
    logic [NUM_SLAVES-1:0] req_dec;
    logic                 req_mapped;
    logic                 slave_ack;
    logic [31:0]          slave_rdt;
    logic [CNT_W-1:0]     cnt;
    logic                 timeout_hit;
    logic                 err_q;
    logic                 accept;
    logic                 done_ok;
    logic                 done_tmo;

    // Address decode and ack/data selection; only the channel whose cyc is high counts.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        req_dec   = '0;
        slave_rdt = '0;
        req_idx   = i_wb_cpu_adr[SEL_MSB -: SEL_WIDTH];
        for (int n = 0; n < NUM_SLAVES; n++) begin
            req_dec[n] = (req_idx == SEL_WIDTH'(n));
            if (o_wb_s_cyc[n])
                slave_rdt = slave_rdt | i_wb_s_rdt[32*n +: 32];
        end
    end

    assign req_mapped  = |req_dec;
    assign slave_ack   = |(i_wb_s_ack & o_wb_s_cyc);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_TERM);

    // A slave ack beats the terminal count in the same cycle.
    assign accept   = (state == IDLE) && i_wb_cpu_cyc;
    assign done_ok  = (state == BUSY) && i_wb_cpu_cyc && slave_ack;
    assign done_tmo = (state == BUSY) && i_wb_cpu_cyc && !slave_ack && timeout_hit;

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = req_mapped ? BUSY : RESP;
            BUSY: begin
                if (!i_wb_cpu_cyc)
                    state_nxt = IDLE;
                else if (done_ok || done_tmo)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = GAP;
            // serv drops cyc one cycle after ack, so this cycle never samples it.
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_wb_cpu_ack = (state == RESP);
        o_err        = (state == RESP) && err_q;
    end

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            o_wb_s_adr   <= '0;
            o_wb_s_dat   <= '0;
            o_wb_s_sel   <= '0;
            o_wb_s_we    <= 1'b0;
            o_wb_s_cyc   <= '0;
            o_wb_cpu_rdt <= '0;
            o_err_adr    <= '0;
            err_q        <= 1'b0;
            cnt          <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            if (accept) begin
                o_wb_s_adr <= i_wb_cpu_adr;
                o_wb_s_dat <= i_wb_cpu_dat;
                o_wb_s_sel <= i_wb_cpu_sel;
                o_wb_s_we  <= i_wb_cpu_we;
                o_wb_s_cyc <= req_dec;
                cnt        <= '0;
                err_q      <= !req_mapped;
                if (!req_mapped) begin
                    o_wb_cpu_rdt <= ERR_DATA;
                    o_err_adr    <= i_wb_cpu_adr;
                end
            end

            if (state == BUSY) begin
                if (!i_wb_cpu_cyc || slave_ack || timeout_hit)
                    o_wb_s_cyc <= '0;
                else if (TIMEOUT != 0)
                    cnt <= cnt + CNT_W'(1);
            end

            if (done_ok) begin
                o_wb_cpu_rdt <= o_wb_s_we ? 32'h0 : slave_rdt;
                err_q        <= 1'b0;
            end

            if (done_tmo) begin
                o_wb_cpu_rdt <= ERR_DATA;
                o_err_adr    <= o_wb_s_adr;
                err_q        <= 1'b1;
            end
        end
    end

endmodule
